lfsr_xor_stream_cipher: RTL

//  Parametrised LFSR keystream XOR cipher with valid/ready streaming ports and a parallel key load.

---
 rtl/cipher_pkg.sv | 17 +
 rtl/galois_lfsr.sv | 32 +++
 rtl/lfsr_xor_stream_cipher.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cipher_pkg.sv
// Shared types and default Galois feedback masks for the LFSR keystream cipher.
package cipher_pkg;

    // Session FSM: NOKEY until the first key load, then IDLE -> GEN -> OUT per word
    typedef enum logic [1:0] {
        ST_NOKEY = 2'd0,
        ST_IDLE  = 2'd1,
        ST_GEN   = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // Maximal-length Galois feedback masks (right-shifting form, feedback from bit 0)
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

endpackage

// File: rtl/galois_lfsr.sv
// Right-shifting Galois LFSR with parallel seed load and a single-step enable.
// The load has priority over the step so a key load always lands cleanly.
module galois_lfsr #(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] state,
    output logic              out_bit
);

    logic [LFSR_W-1:0] lfsr_r;

    // LFSR register: seed load wins, otherwise one Galois shift per step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_r <= {LFSR_W{1'b0}};
        end else if (load) begin
            lfsr_r <= seed;
        end else if (step) begin
            lfsr_r <= (lfsr_r >> 1) ^ (lfsr_r[0] ? TAPS : {LFSR_W{1'b0}});
        end
    end

    assign state   = lfsr_r;
    assign out_bit = lfsr_r[0];

endmodule

// File: rtl/lfsr_xor_stream_cipher.sv
// LFSR keystream XOR cipher with valid/ready streaming ports. One LFSR step
// produces one keystream bit; a word takes DATA_W steps. Encrypt == decrypt.
// The LFSR runs continuously across words for the whole keyed session.
module lfsr_xor_stream_cipher
    import cipher_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = TAPS_16,
    parameter int                CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_load_i,
    input  logic [LFSR_W-1:0] key_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              keyed_o,
    output logic [CNT_W-1:0]  word_cnt_o
);

    localparam int             BC_W    = $clog2(DATA_W + 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

    state_e            state_r;
    state_e            state_s;
    logic [BC_W-1:0]   bit_cnt_r;
    logic [DATA_W-1:0] ks_r;
    logic [DATA_W-1:0] ks_next_s;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_valid_r;
    logic              keyed_r;
    logic [CNT_W-1:0]  word_cnt_r;
    logic [LFSR_W-1:0] seed_s;
    logic              step_s;
    logic              last_bit_s;
    logic              lfsr_bit_s;
    // Full LFSR state is only kept for debug visibility
    logic [LFSR_W-1:0] lfsr_dbg_unused_s;

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    assign seed_s     = (key_i == {LFSR_W{1'b0}}) ? LFSR_W'(1) : key_i;
    assign step_s     = (state_r == ST_GEN) & ~key_load_i;
    assign last_bit_s = (bit_cnt_r == BC_LAST);
    assign ks_next_s  = {lfsr_bit_s, ks_r[DATA_W-1:1]};
    assign in_ready_o = (state_r == ST_IDLE) & ~key_load_i;

    galois_lfsr #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (key_load_i),
        .seed    (seed_s),
        .step    (step_s),
        .state   (lfsr_dbg_unused_s),
        .out_bit (lfsr_bit_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_NOKEY;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state: key load overrides everything, else normal word flow
    always_comb begin
        state_s = state_r;
        if (key_load_i) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_NOKEY: state_s = ST_NOKEY;
                ST_IDLE:  state_s = in_valid_i  ? ST_GEN  : ST_IDLE;
                ST_GEN:   state_s = last_bit_s  ? ST_OUT  : ST_GEN;
                ST_OUT:   state_s = out_ready_i ? ST_IDLE : ST_OUT;
                default:  state_s = ST_NOKEY;
            endcase
        end
    end

    // Datapath: word capture, keystream accumulation, output and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_r   <= {BC_W{1'b0}};
            ks_r        <= {DATA_W{1'b0}};
            data_r      <= {DATA_W{1'b0}};
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            keyed_r     <= 1'b0;
            word_cnt_r  <= {CNT_W{1'b0}};
        end else if (key_load_i) begin
            bit_cnt_r   <= {BC_W{1'b0}};
            out_valid_r <= 1'b0;
            keyed_r     <= 1'b1;
            word_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        data_r    <= in_data_i;
                        bit_cnt_r <= {BC_W{1'b0}};
                    end
                end
                ST_GEN: begin
                    ks_r      <= ks_next_s;
                    bit_cnt_r <= bit_cnt_r + BC_W'(1);
                    if (last_bit_s) begin
                        out_data_r  <= data_r ^ ks_next_s;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready_i) begin
                        out_valid_r <= 1'b0;
                        word_cnt_r  <= word_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid_o = out_valid_r;
    assign out_data_o  = out_data_r;
    assign keyed_o     = keyed_r;
    assign word_cnt_o  = word_cnt_r;

endmodule
